// File: rtl/n_clic_pend_ctrl_pkg.sv
// Shared types and limits for the CLIC pend-bit controller.
package n_clic_pend_ctrl_pkg;
    localparam int MaxVecSize = 32;

    typedef enum logic {
        PendLevel = 1'b0,
        PendEdge  = 1'b1
    } pend_mode_t;
endpackage

// File: rtl/n_clic_pend_ctrl_if.sv
// Bus between the pads/CSR/dispatch logic (master) and the pend controller (slave).
interface n_clic_pend_ctrl_if #(
    parameter int VecSize  = 8,
    parameter int VecWidth = (VecSize > 1) ? $clog2(VecSize) : 1
) ();
    logic [VecSize-1:0]  irq_in;
    logic [VecSize-1:0]  pend_mode;
    logic                sw_we;
    logic [VecWidth-1:0] sw_idx;
    logic                sw_pend;
    logic                take_valid;
    logic [VecWidth-1:0] take_idx;
    logic                overrun_clr;
    logic [VecSize-1:0]  pended;
    logic [VecSize-1:0]  overrun;
    logic [VecWidth:0]   pend_cnt;

    modport master (
        output irq_in, pend_mode, sw_we, sw_idx, sw_pend,
               take_valid, take_idx, overrun_clr,
        input  pended, overrun, pend_cnt
    );

    modport slave (
        input  irq_in, pend_mode, sw_we, sw_idx, sw_pend,
               take_valid, take_idx, overrun_clr,
        output pended, overrun, pend_cnt
    );
endinterface

// File: rtl/n_clic_pend_ctrl_irq_sync_edge.sv
// Multi-flop synchroniser for one IRQ line with a registered rising-edge detector.
module irq_sync_edge #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q_sync,
    output logic q_rise
);
    logic [SyncStages-1:0] sync_q;
    logic                  hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d};
            hist_q <= sync_q[SyncStages-1];
        end
    end

    assign q_sync = sync_q[SyncStages-1];
    assign q_rise = q_sync & ~hist_q;
endmodule

// File: rtl/n_clic_pend_ctrl.sv
// CLIC pend-bit controller: per-vector pend/overrun arbitration over synchronised IRQ sources.
module n_clic_pend_ctrl
    import n_clic_pend_ctrl_pkg::*;
#(
    parameter int VecSize    = 8,
    parameter int VecWidth   = (VecSize > 1) ? $clog2(VecSize) : 1,
    parameter int SyncStages = 2
) (
    input  logic                clk,
    input  logic                reset,
    n_clic_pend_ctrl_if.slave   bus
);
    logic [VecSize-1:0] sync_w, rise_w;
    logic [VecSize-1:0] pended_q, pended_d;
    logic [VecSize-1:0] overrun_q, overrun_d;
    logic [VecWidth:0]  cnt_q, cnt_d;

    for (genvar g = 0; g < VecSize; g++) begin : g_sync
        irq_sync_edge #(.SyncStages(SyncStages)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .d      (bus.irq_in[g]),
            .q_sync (sync_w[g]),
            .q_rise (rise_w[g])
        );
    end

    // Software write beats a new event, which beats a dispatch clear; out-of-range indices never match.
    always_comb begin
        logic set_k, sw_k, tk_k;
        pended_d  = pended_q;
        overrun_d = overrun_q;
        cnt_d     = '0;
        for (int k = 0; k < VecSize; k++) begin
            set_k = (pend_mode_t'(bus.pend_mode[k]) == PendEdge) ? rise_w[k] : sync_w[k];
            sw_k  = bus.sw_we && (int'(bus.sw_idx) == k);
            tk_k  = bus.take_valid && (int'(bus.take_idx) == k);

            if (sw_k)       pended_d[k] = bus.sw_pend;
            else if (set_k) pended_d[k] = 1'b1;
            else if (tk_k)  pended_d[k] = 1'b0;

            if (set_k && pended_q[k] && !tk_k && !sw_k) overrun_d[k] = 1'b1;
            else if (bus.overrun_clr)                   overrun_d[k] = 1'b0;
        end
        for (int k = 0; k < VecSize; k++) begin
            cnt_d = cnt_d + {{VecWidth{1'b0}}, pended_d[k]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pended_q  <= '0;
            overrun_q <= '0;
            cnt_q     <= '0;
        end else begin
            pended_q  <= pended_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pended   = pended_q;
    assign bus.overrun  = overrun_q;
    assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_n_clic_pend_ctrl.sv
// Directed and randomised bench for n_clic_pend_ctrl against a cycle-level behavioural model.
module tb_n_clic_pend_ctrl;
    localparam int VS = 8;
    localparam int VW = 3;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    n_clic_pend_ctrl_if #(.VecSize(VS), .VecWidth(VW)) bus ();

    n_clic_pend_ctrl #(.VecSize(VS), .VecWidth(VW), .SyncStages(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: raw irq samples taken at past edges (irqh[0] newest), plus flags.
    logic [VS-1:0] irqh [0:SS];
    logic [VS-1:0] m_pend, m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= SS; i++) irqh[i] = '0;
        m_pend = '0;
        m_ovr  = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pended"},   32'(bus.pended),   32'(m_pend));
        check({tag, ".overrun"},  32'(bus.overrun),  32'(m_ovr));
        check({tag, ".pend_cnt"}, 32'(bus.pend_cnt), 32'($countones(m_pend)));
    endtask

    // One clock: evaluate the pend rules on the values seen before the edge, then compare.
    task automatic tick(input string tag);
        logic [VS-1:0] s_old, h_old, np, no;
        logic set, sw, tk;
        s_old = irqh[SS-1];
        h_old = irqh[SS];
        np = m_pend;
        no = m_ovr;
        for (int k = 0; k < VS; k++) begin
            set = bus.pend_mode[k] ? (s_old[k] && !h_old[k]) : s_old[k];
            sw  = bus.sw_we && (bus.sw_idx == k);
            tk  = bus.take_valid && (bus.take_idx == k);
            if (sw)       np[k] = bus.sw_pend;
            else if (set) np[k] = 1'b1;
            else if (tk)  np[k] = 1'b0;
            if (set && m_pend[k] && !tk && !sw) no[k] = 1'b1;
            else if (bus.overrun_clr)           no[k] = 1'b0;
        end
        for (int i = SS; i > 0; i--) irqh[i] = irqh[i-1];
        irqh[0] = bus.irq_in;
        m_pend = np;
        m_ovr  = no;
        if (!reset) model_reset();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.sw_we = 1'b0; bus.sw_idx = '0; bus.sw_pend = 1'b0;
        bus.take_valid = 1'b0; bus.take_idx = '0; bus.overrun_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.irq_in = '0;
        bus.pend_mode = '0;
        idle_inputs();
        model_reset();
        #2;
        check("reset.pended",   32'(bus.pended),   32'h0);
        check("reset.overrun",  32'(bus.overrun),  32'h0);
        check("reset.pend_cnt", 32'(bus.pend_cnt), 32'h0);
        #14 reset = 1'b1;
        tick("idle"); tick("idle");

        // 1: edge pend latency and hold after pulse
        bus.pend_mode = 8'h08;
        bus.irq_in[3] = 1'b1;
        tick("edge"); tick("edge");
        check("edge.early", 32'(bus.pended[3]), 32'h0);
        tick("edge");
        check("edge.set", 32'(bus.pended[3]), 32'h1);
        bus.irq_in[3] = 1'b0;
        tick("edge"); tick("edge");
        check("edge.hold", 32'(bus.pended[3]), 32'h1);
        check("edge.cnt",  32'(bus.pend_cnt),  32'h1);

        // 2: take coinciding with a new edge, then a plain take
        bus.irq_in[3] = 1'b1;
        tick("take"); tick("take");
        bus.take_valid = 1'b1; bus.take_idx = 3'd3;
        tick("take.race");
        check("take.race.pend", 32'(bus.pended[3]),  32'h1);
        check("take.race.ovr",  32'(bus.overrun[3]), 32'h0);
        tick("take.clear");
        check("take.clear.pend", 32'(bus.pended[3]), 32'h0);
        check("take.clear.cnt",  32'(bus.pend_cnt),  32'h0);
        bus.take_valid = 1'b0;
        bus.irq_in[3] = 1'b0;

        // 3: overrun on vector 5, then clear
        bus.pend_mode[5] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.irq_in[5] = 1'b1; tick("ovr");
            bus.irq_in[5] = 1'b0; tick("ovr");
        end
        tick("ovr"); tick("ovr");
        check("ovr.pend", 32'(bus.pended[5]),  32'h1);
        check("ovr.flag", 32'(bus.overrun[5]), 32'h1);
        bus.overrun_clr = 1'b1;
        tick("ovr.clr");
        bus.overrun_clr = 1'b0;
        check("ovr.clr.flag", 32'(bus.overrun[5]), 32'h0);
        check("ovr.clr.pend", 32'(bus.pended[5]),  32'h1);

        // 4: level mode re-pends while the source is high
        bus.pend_mode[1] = 1'b0;
        bus.irq_in[1] = 1'b1;
        tick("lvl"); tick("lvl"); tick("lvl");
        bus.take_valid = 1'b1; bus.take_idx = 3'd1;
        tick("lvl.take.hi");
        check("lvl.take.hi", 32'(bus.pended[1]), 32'h1);
        bus.take_valid = 1'b0;
        bus.irq_in[1] = 1'b0;
        tick("lvl"); tick("lvl"); tick("lvl");
        bus.take_valid = 1'b1;
        tick("lvl.take.lo");
        check("lvl.take.lo", 32'(bus.pended[1]), 32'h0);
        bus.take_valid = 1'b0;

        // 5: software write priority
        bus.pend_mode[2] = 1'b1;
        bus.irq_in[2] = 1'b1;
        tick("sw"); tick("sw");
        bus.sw_we = 1'b1; bus.sw_idx = 3'd2; bus.sw_pend = 1'b0;
        tick("sw.beats.set");
        check("sw.beats.set", 32'(bus.pended[2]), 32'h0);
        bus.sw_idx = 3'd7; bus.sw_pend = 1'b1;
        tick("sw.set7");
        check("sw.set7", 32'(bus.pended[7]), 32'h1);
        idle_inputs();
        bus.irq_in = '0;

        // 6: async reset mid-cycle discards pends
        bus.sw_we = 1'b1; bus.sw_pend = 1'b1;
        bus.sw_idx = 3'd0; tick("rst.prep");
        bus.sw_idx = 3'd4; tick("rst.prep");
        bus.sw_idx = 3'd6; tick("rst.prep");
        idle_inputs();
        check("rst.prep.bits", 32'(bus.pended & 8'h51), 32'h51);
        #3 reset = 1'b0;
        #1;
        check("rst.async.pended",  32'(bus.pended),   32'h0);
        check("rst.async.overrun", 32'(bus.overrun),  32'h0);
        check("rst.async.cnt",     32'(bus.pend_cnt), 32'h0);
        model_reset();
        tick("rst.hold");
        #3 reset = 1'b1;
        for (int i = 0; i < 5; i++) tick("rst.after");
        check("rst.no.spurious", 32'(bus.pended), 32'h0);

        // Randomised traffic against the model, with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) bus.pend_mode = 8'($urandom);
            bus.irq_in      = 8'($urandom);
            bus.sw_we       = ($urandom_range(0, 7) == 0);
            bus.sw_idx      = 3'($urandom);
            bus.sw_pend     = 1'($urandom);
            bus.take_valid  = ($urandom_range(0, 3) == 0);
            bus.take_idx    = 3'($urandom);
            bus.overrun_clr = ($urandom_range(0, 15) == 0);
            if (i == 200) begin
                #4 reset = 1'b0;
                model_reset();
                #1 check_all("rand.rst");
                tick("rand.rst");
                #3 reset = 1'b1;
            end
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
